// File: rtl/lc3b_types.sv
// lc3b_types: shared word and pipeline-bundle types for the LC-3b pipeline.
//   lc3b_word          16-bit machine word
//   lc3b_control_word  control bits carried from decode to writeback
//   EX_MEM             bundle from EX into MEM
//   MEM_WB             bundle from MEM into WB
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        logic       load_regfile;
        logic       load_cc;
        logic [1:0] regfile_mux_sel;
        logic [2:0] dest;
        logic       br_en;
    } lc3b_control_word;

    typedef struct packed {
        lc3b_word         intr;
        lc3b_word         pc_out;
        lc3b_word         alu_out;
        lc3b_word         srcb_out;
        lc3b_control_word control_signals;
    } EX_MEM;

    typedef struct packed {
        lc3b_word         intr;
        lc3b_word         pc_out;
        lc3b_word         alu_out;
        lc3b_word         mem_data;
        lc3b_control_word control_signals;
    } MEM_WB;

endpackage

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage. Performs the data-memory access for
// LDR/STR/LDB/STB/LDI/STI (two accesses for the indirect ops), stalls the
// upstream pipeline while an access is outstanding and registers the
// MEM_WB bundle for writeback.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   ex_mem_in          EX_MEM bundle from the EX stage
//   ex_mem_valid       ex_mem_in holds a real instruction (0 = bubble)
//   dmem_rdata         data memory read data
//   dmem_resp          data memory completes the current access this cycle
//   dmem_address       data memory word address (bit 0 always 0)
//   dmem_read/write    request strobes, never both 1
//   dmem_wdata         write data
//   dmem_byte_enable   [1] = high byte, [0] = low byte
//   mem_stall          1 = EX and earlier stages hold their state
//   mem_wb_out         registered bundle for WB
//   mem_wb_valid       mem_wb_out holds a real instruction
//
// Handshakes: a memory request is open while dmem_read or dmem_write is 1;
// address, strobes, wdata and byte enables are held stable until the cycle
// in which dmem_resp = 1, and that cycle completes the access. A dmem_resp
// without an open request is ignored. Upstream, ex_mem_in is consumed on an
// edge where mem_stall = 0; while mem_stall = 1 the upstream holds it and a
// bubble (mem_wb_valid = 0) is sent to WB.
module mem_access_stage
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  EX_MEM       ex_mem_in,
    input  logic        ex_mem_valid,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        mem_stall,
    output MEM_WB       mem_wb_out,
    output logic        mem_wb_valid
);

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic {
        IDLE     = 1'b0,
        INDIRECT = 1'b1
    } state_t;

    state_t   state;
    logic     ind_gap;    // first cycle in INDIRECT: no request yet
    lc3b_word ind_addr;   // pointer fetched by the first indirect access

    logic [3:0] opcode;
    lc3b_word   word_addr;
    logic       is_ind;
    logic       go_ind;
    logic       req_read;
    logic       req_write;
    lc3b_word   load_data;
    lc3b_word   byte_sel;

    assign opcode    = ex_mem_in.intr[15:12];
    assign word_addr = {ex_mem_in.alu_out[15:1], 1'b0};
    assign is_ind    = ex_mem_valid && (opcode == OP_LDI || opcode == OP_STI);

    // Request generation and stall.
    always_comb begin
        dmem_address     = word_addr;
        dmem_wdata       = ex_mem_in.srcb_out;
        dmem_byte_enable = 2'b11;
        req_read         = 1'b0;
        req_write        = 1'b0;
        mem_stall        = 1'b0;
        go_ind           = 1'b0;
        case (state)
            IDLE: begin
                if (ex_mem_valid) begin
                    case (opcode)
                        OP_LDR, OP_LDB, OP_LDI, OP_STI: req_read = 1'b1;
                        OP_STR: req_write = 1'b1;
                        OP_STB: begin
                            req_write        = 1'b1;
                            dmem_wdata       = {ex_mem_in.srcb_out[7:0],
                                                ex_mem_in.srcb_out[7:0]};
                            dmem_byte_enable = ex_mem_in.alu_out[0] ? 2'b10 : 2'b01;
                        end
                        default: ;
                    endcase
                end
                if (req_read || req_write) begin
                    // Indirect ops keep stalling through the pointer fetch.
                    mem_stall = !dmem_resp || is_ind;
                    go_ind    = dmem_resp && is_ind;
                end
            end
            INDIRECT: begin
                dmem_address = ind_addr;
                if (!ind_gap) begin
                    if (opcode == OP_STI) req_write = 1'b1;
                    else                  req_read  = 1'b1;
                end
                mem_stall = ind_gap || !dmem_resp;
            end
            default: ;
        endcase
    end

    // Reset kills the strobes immediately, without waiting for an edge.
    assign dmem_read  = req_read  && !reset;
    assign dmem_write = req_write && !reset;

    assign byte_sel = ex_mem_in.alu_out[0]
                    ? {{8{dmem_rdata[15]}}, dmem_rdata[15:8]}
                    : {{8{dmem_rdata[7]}},  dmem_rdata[7:0]};

    // Data captured into MEM_WB; stores, non-memory ops and bubbles give 0.
    always_comb begin
        load_data = '0;
        if (ex_mem_valid) begin
            case (opcode)
                OP_LDR, OP_LDI: load_data = dmem_rdata;
                OP_LDB:         load_data = byte_sel;
                default:        load_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ind_gap      <= 1'b0;
            ind_addr     <= '0;
            mem_wb_out   <= '0;
            mem_wb_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_ind) begin
                        state    <= INDIRECT;
                        ind_gap  <= 1'b1;
                        ind_addr <= {dmem_rdata[15:1], 1'b0};
                    end
                end
                INDIRECT: begin
                    if (ind_gap)        ind_gap <= 1'b0;
                    else if (dmem_resp) state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (mem_stall) begin
                mem_wb_valid <= 1'b0;
            end else begin
                mem_wb_out.intr            <= ex_mem_in.intr;
                mem_wb_out.pc_out          <= ex_mem_in.pc_out;
                mem_wb_out.alu_out         <= ex_mem_in.alu_out;
                mem_wb_out.mem_data        <= load_data;
                mem_wb_out.control_signals <= ex_mem_in.control_signals;
                mem_wb_valid               <= ex_mem_valid;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import lc3b_types::*;

    localparam int CW = 96;
    localparam int W  = $bits(MEM_WB);

    logic        clk = 1'b0;
    logic        reset;
    EX_MEM       ex_mem_in;
    logic        ex_mem_valid;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic [15:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        mem_stall;
    MEM_WB       mem_wb_out;
    logic        mem_wb_valid;

    mem_access_stage dut (
        .clk(clk), .reset(reset),
        .ex_mem_in(ex_mem_in), .ex_mem_valid(ex_mem_valid),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dmem_address(dmem_address), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable), .mem_stall(mem_stall),
        .mem_wb_out(mem_wb_out), .mem_wb_valid(mem_wb_valid)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } acc_t;

    acc_t        acc_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_wb;
    logic [15:0]  mem_model [logic [15:0]];

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (!mem_model.exists(a)) mem_model[a] = 16'($urandom);
        return mem_model[a];
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] b);
        int v;
        v = (int'(b) >= 128) ? int'(b) - 256 : int'(b);
        return 16'(v);
    endfunction

    // Reference model: list of accesses the instruction must make and the
    // MEM_WB contents it must produce.
    task automatic build_expect(input EX_MEM e, input logic v);
        MEM_WB       wb;
        acc_t        a;
        logic [15:0] ea, p, r;
        logic [3:0]  op;
        op = e.intr[15:12];
        ea = e.alu_out & 16'hFFFE;
        wb.intr = e.intr;
        wb.pc_out = e.pc_out;
        wb.alu_out = e.alu_out;
        wb.mem_data = 16'h0;
        wb.control_signals = e.control_signals;
        acc_q.delete();
        a = '0;
        if (v) begin
            case (op)
                4'b0110: begin
                    r = mem_rd(ea);
                    a = '{addr: ea, wr: 1'b0, be: 2'b11, wdata: 16'h0, rdata: r};
                    acc_q.push_back(a);
                    wb.mem_data = r;
                end
                4'b0111: begin
                    a = '{addr: ea, wr: 1'b1, be: 2'b11, wdata: e.srcb_out, rdata: 16'h0};
                    acc_q.push_back(a);
                end
                4'b0010: begin
                    r = mem_rd(ea);
                    a = '{addr: ea, wr: 1'b0, be: 2'b11, wdata: 16'h0, rdata: r};
                    acc_q.push_back(a);
                    wb.mem_data = e.alu_out[0] ? sext8(r[15:8]) : sext8(r[7:0]);
                end
                4'b0011: begin
                    a = '{addr: ea, wr: 1'b1, be: (e.alu_out[0] ? 2'b10 : 2'b01),
                          wdata: {e.srcb_out[7:0], e.srcb_out[7:0]}, rdata: 16'h0};
                    acc_q.push_back(a);
                end
                4'b1010, 4'b1011: begin
                    p = mem_rd(ea);
                    a = '{addr: ea, wr: 1'b0, be: 2'b11, wdata: 16'h0, rdata: p};
                    acc_q.push_back(a);
                    p = p & 16'hFFFE;
                    if (op == 4'b1010) begin
                        r = mem_rd(p);
                        a = '{addr: p, wr: 1'b0, be: 2'b11, wdata: 16'h0, rdata: r};
                        wb.mem_data = r;
                    end else begin
                        a = '{addr: p, wr: 1'b1, be: 2'b11, wdata: e.srcb_out, rdata: 16'h0};
                    end
                    acc_q.push_back(a);
                end
                default: ;
            endcase
        end
        exp_q.push_back(W'(wb));
    endtask

    task automatic apply_write(input acc_t a);
        logic [15:0] m;
        m = mem_rd(a.addr);
        if (a.be[1]) m[15:8] = a.wdata[15:8];
        if (a.be[0]) m[7:0]  = a.wdata[7:0];
        mem_model[a.addr] = m;
    endtask

    task automatic check_wb(input string tag, input logic v);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, CW'(0), CW'(1));
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_valid"}, CW'(mem_wb_valid), CW'(v));
        check({tag, "_bundle"}, CW'(mem_wb_out), CW'(e));
        last_wb = e;
    endtask

    task automatic check_request(input acc_t a, input string tag);
        check({tag, "_addr"}, CW'(dmem_address), CW'(a.addr));
        check({tag, "_read"}, CW'(dmem_read), CW'(!a.wr));
        check({tag, "_write"}, CW'(dmem_write), CW'(a.wr));
        check({tag, "_be"}, CW'(dmem_byte_enable), CW'(a.be));
        if (a.wr) check({tag, "_wdata"}, CW'(dmem_wdata), CW'(a.wdata));
    endtask

    // ---------------- driver ----------------
    // Presents one instruction and services its accesses. lat < 0 picks a
    // random number of wait cycles before each response.
    task automatic run_op(input EX_MEM e, input logic v, input int lat);
        int   n, idle, nacc;
        bit   seen, first;
        acc_t a;
        build_expect(e, v);
        nacc = acc_q.size();
        ex_mem_in = e;
        ex_mem_valid = v;
        if (nacc == 0) begin
            @(negedge clk);
            dmem_resp  = 1'($urandom_range(0, 1));   // stray resp must be ignored
            dmem_rdata = 16'($urandom);
            #1;
            check("nm_read", CW'(dmem_read), CW'(0));
            check("nm_write", CW'(dmem_write), CW'(0));
            check("nm_stall", CW'(mem_stall), CW'(0));
            @(posedge clk); #1;
            dmem_resp = 1'b0;
            check_wb("nm_wb", v);
            return;
        end
        first = 1'b1;
        for (int k = 0; k < nacc; k++) begin
            a = acc_q[k];
            idle = 0;
            seen = 1'b0;
            while (!seen && idle < 20) begin
                @(negedge clk);
                dmem_resp = 1'b0;
                #1;
                if (!first) begin
                    check("hold_valid", CW'(mem_wb_valid), CW'(0));
                    check("hold_bundle", CW'(mem_wb_out), CW'(last_wb));
                end
                first = 1'b0;
                if (dmem_read || dmem_write) begin
                    seen = 1'b1;
                end else begin
                    idle++;
                    dmem_resp  = 1'($urandom_range(0, 1));
                    dmem_rdata = 16'($urandom);
                    #1;
                    check("gap_stall", CW'(mem_stall), CW'(1));
                    @(posedge clk); #1;
                    dmem_resp = 1'b0;
                end
            end
            if (!seen) begin
                check("req_timeout", CW'(0), CW'(1));
                return;
            end
            check(k == 0 ? "first_gap" : "ind_gap", CW'(idle), CW'(k == 0 ? 0 : 1));
            check_request(a, "req");
            n = (lat < 0) ? $urandom_range(0, 3) : lat;
            for (int j = 0; j < n; j++) begin
                check("wait_stall", CW'(mem_stall), CW'(1));
                @(posedge clk); #1;
                @(negedge clk); #1;
                check_request(a, "hold");
                check("wait_valid", CW'(mem_wb_valid), CW'(0));
                check("wait_bundle", CW'(mem_wb_out), CW'(last_wb));
            end
            dmem_resp  = 1'b1;
            dmem_rdata = a.wr ? 16'($urandom) : a.rdata;
            #1;
            check("resp_stall", CW'(mem_stall), CW'(k == nacc - 1 ? 0 : 1));
            if (a.wr) apply_write(a);
            @(posedge clk); #1;
            dmem_resp = 1'b0;
        end
        check_wb("mem_wb", 1'b1);
    endtask

    function automatic EX_MEM mk(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] srcb);
        EX_MEM e;
        e.intr = {op, 12'($urandom)};
        e.pc_out = 16'($urandom);
        e.alu_out = alu;
        e.srcb_out = srcb;
        e.control_signals = 8'($urandom);
        return e;
    endfunction

    // ---------------- stimulus ----------------
    logic [3:0] op_tab [10] = '{4'h1, 4'h5, 4'h0, 4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB, 4'hE};

    initial begin
        EX_MEM e;
        int    stall_cycles;

        reset = 1'b1;
        dmem_resp = 1'b0;
        dmem_rdata = 16'h0;
        ex_mem_in = mk(4'h6, 16'h1234, 16'h0);   // LDR held during reset
        ex_mem_valid = 1'b1;
        #1;
        check("rst_read", CW'(dmem_read), CW'(0));
        check("rst_write", CW'(dmem_write), CW'(0));
        check("rst_valid", CW'(mem_wb_valid), CW'(0));
        check("rst_bundle", CW'(mem_wb_out), CW'(0));
        ex_mem_in = '0;
        ex_mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        last_wb = '0;

        // 1: ADD
        e = mk(4'h1, 16'h0005, 16'h0);
        e.intr = 16'h1261;
        run_op(e, 1'b1, 0);
        check("t1_alu", CW'(mem_wb_out.alu_out), CW'(16'h0005));

        // 2: LDR, resp on the third request cycle
        mem_model[16'h1234] = 16'hBEEF;
        run_op(mk(4'h6, 16'h1235, 16'h0), 1'b1, 2);
        check("t2_data", CW'(mem_wb_out.mem_data), CW'(16'hBEEF));

        // 3: STB high and low byte
        run_op(mk(4'h3, 16'h2001, 16'h00A5), 1'b1, 0);
        run_op(mk(4'h3, 16'h2000, 16'h00A5), 1'b1, 1);

        // 4: LDB sign extension, both bytes
        mem_model[16'h3000] = 16'h80FF;
        run_op(mk(4'h2, 16'h3001, 16'h0), 1'b1, 0);
        check("t4_hi", CW'(mem_wb_out.mem_data), CW'(16'hFF80));
        mem_model[16'h3000] = 16'h807F;
        run_op(mk(4'h2, 16'h3000, 16'h0), 1'b1, 1);
        check("t4_lo", CW'(mem_wb_out.mem_data), CW'(16'h007F));

        // 5: LDI through pointer 0x5001
        mem_model[16'h4000] = 16'h5001;
        mem_model[16'h5000] = 16'h1357;
        run_op(mk(4'hA, 16'h4000, 16'h0), 1'b1, 1);
        check("t5_data", CW'(mem_wb_out.mem_data), CW'(16'h1357));

        // 6: STI aborted by reset while in INDIRECT
        mem_model[16'h6000] = 16'h7003;
        ex_mem_in = mk(4'hB, 16'h6000, 16'h4242);
        ex_mem_valid = 1'b1;
        @(negedge clk); #1;
        check("t6_ptr_read", CW'(dmem_read), CW'(1));
        dmem_resp = 1'b1;
        dmem_rdata = 16'h7003;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        stall_cycles = 0;
        @(negedge clk); #1;                       // gap cycle
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("t6_ind_write", CW'(dmem_write), CW'(1));
        check("t6_ind_addr", CW'(dmem_address), CW'(16'h7002));
        reset = 1'b1;
        #1;
        check("t6_rst_read", CW'(dmem_read), CW'(0));
        check("t6_rst_write", CW'(dmem_write), CW'(0));
        check("t6_rst_valid", CW'(mem_wb_valid), CW'(0));
        ex_mem_in = '0;
        ex_mem_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_bundle", CW'(mem_wb_out), CW'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        last_wb = '0;
        stall_cycles = stall_cycles + 0;
        run_op(mk(4'h1, 16'h0777, 16'h0), 1'b1, 0);
        check("t6_add_alu", CW'(mem_wb_out.alu_out), CW'(16'h0777));
        run_op(mk(4'h6, 16'h0100, 16'h0), 1'b1, 0);  // must start in IDLE

        // randomized mix
        for (int i = 0; i < 300; i++) begin
            logic [15:0] alu;
            alu = 16'($urandom);
            e = mk(op_tab[$urandom_range(0, 9)], alu, 16'($urandom));
            run_op(e, ($urandom_range(0, 4) != 0), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage, directly downstream of EX. Consumes the EX_MEM bundle and performs data-memory access for LDR/STR/LDB/STB/LDI/STI, including two-access indirect sequencing.
- Produces the registered MEM_WB bundle for writeback.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- none. Widths are fixed by lc3b_types: word = 16 bits; EX_MEM and MEM_WB are packed structs.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ex_mem_in  input  $bits(EX_MEM)  EX_MEM bundle; fields used: intr, pc_out, alu_out, srcb_out, control_signals
- ex_mem_valid  input  1  ex_mem_in holds a real instruction (0 = bubble)
- dmem_rdata  input  16  read data from data memory
- dmem_resp  input  1  data memory completes the current access this cycle
- dmem_address  output  16  data memory address
- dmem_read  output  1  read request
- dmem_write  output  1  write request
- dmem_wdata  output  16  write data
- dmem_byte_enable  output  2  [1] = high byte, [0] = low byte
- mem_stall  output  1  1 = EX and earlier stages must hold their state
- mem_wb_out  output  $bits(MEM_WB)  registered bundle: intr, pc_out, alu_out, mem_data, control_signals
- mem_wb_valid  output  1  mem_wb_out holds a real instruction

Behaviour:
- Opcode is intr[15:12]. Memory ops: LDB 0010, STB 0011, LDR 0110, STR 0111, LDI 1010, STI 1011. Every other opcode, and any bubble, is a non-memory op.
- FSM states:
  - IDLE: first or only access.
  - INDIRECT: second access of LDI/STI.
- Reset (async): state = IDLE; mem_wb_out = 0; mem_wb_valid = 0; ind_addr = 0. dmem_read and dmem_write are 0 immediately, without waiting for a clock edge.
- Non-memory op or bubble:
  - mem_stall = 0; no dmem request.
  - Next edge loads mem_wb_out with intr, pc_out, alu_out, control_signals and mem_data = 0. mem_wb_valid <= ex_mem_valid.
  - Latency: 1 cycle.
- Single-access op, in IDLE with ex_mem_valid = 1:
  - Request is driven combinationally in the same cycle.
  - mem_stall = 1 while dmem_resp = 0.
  - In the cycle where dmem_resp = 1: mem_stall = 0. Next edge loads mem_wb_out and sets mem_wb_valid = 1.
  - Minimum latency is 1 cycle, when resp arrives in the same cycle as the request.
- Word ops (LDR, STR):
  - dmem_address = {alu_out[15:1], 0}; byte_enable = 11.
  - STR: dmem_wdata = srcb_out.
  - LDR: mem_data = dmem_rdata.
- Byte ops (LDB, STB):
  - dmem_address = {alu_out[15:1], 0}; byte select = alu_out[0].
  - STB: dmem_wdata = {srcb_out[7:0], srcb_out[7:0]}; byte_enable = 10 if alu_out[0] = 1, else 01.
  - LDB: mem_data = sign-extended dmem_rdata[15:8] if alu_out[0] = 1, else sign-extended dmem_rdata[7:0]; byte_enable = 11.
- Indirect ops (LDI, STI):
  - IDLE: read the word at {alu_out[15:1], 0}; mem_stall = 1.
  - On dmem_resp in IDLE: latch ind_addr <= {dmem_rdata[15:1], 0}; go to INDIRECT. mem_stall stays 1.
  - INDIRECT: dmem_address = ind_addr, byte_enable = 11.
    - LDI reads; mem_data = dmem_rdata.
    - STI writes; dmem_wdata = srcb_out.
  - On dmem_resp in INDIRECT: mem_stall = 0; return to IDLE; next edge loads mem_wb_out.
- Between the two indirect accesses, dmem_read is 0 for at least the one cycle after the first resp. The INDIRECT request starts the cycle after entering INDIRECT.
- Request hold: once asserted, dmem_address, dmem_read/write, dmem_wdata and byte_enable stay stable until the resp cycle. At most one of dmem_read and dmem_write is 1.
- mem_wb_out is unchanged on every edge where mem_stall = 1. mem_wb_valid is 0 after a stalled edge (bubble into WB).
- dmem_resp arriving with no request outstanding is ignored.
- Reset mid-transaction (IDLE or INDIRECT) aborts the access. No MEM_WB entry is produced for the aborted instruction.

Test Plan:
1. ADD (intr 0x1261), alu_out 0x0005, valid = 1 -> no dmem request; mem_stall = 0; next edge mem_wb_out.alu_out = 0x0005, mem_wb_valid = 1.
2. LDR, alu_out 0x1235, resp after 3 cycles with rdata 0xBEEF -> dmem_address 0x1234, read = 1 for 3 cycles, mem_stall = 1 for the 2 cycles before resp and 0 in the resp cycle; mem_data = 0xBEEF.
3. STB, alu_out 0x2001, srcb_out 0x00A5 -> write = 1, wdata 0xA5A5, byte_enable 10, address 0x2000. With alu_out 0x2000: byte_enable 01.
4. LDB, alu_out 0x3001, rdata 0x80FF -> mem_data 0xFF80. With alu_out 0x3000 and rdata 0x807F -> mem_data 0x007F.
5. LDI, alu_out 0x4000: first resp rdata 0x5001, second resp rdata 0x1357 -> second address 0x5000; mem_stall = 1 throughout until the second resp; mem_data 0x1357; exactly two reads issued.
6. STI with reset asserted while in INDIRECT -> read/write drop to 0 asynchronously; state IDLE; mem_wb_valid = 0. After release, an ADD completes normally in 1 cycle.
